// File: rtl/seg_ser_pkg.sv
// rtl/seg_ser_pkg.sv - shared types and helpers for the display-chain serializer
//
// Purpose: frame FSM state encoding, divider counter width helper and the
// board's default display width, shared by seg_serializer and seg_ser_tick.
// Ports: none (package).
package seg_ser_pkg;

  // Default display chain length on the board (three 8-bit shift registers).
  localparam int unsigned SEG_SER_DEF_WIDTH = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } seg_ser_state_e;

  // Width of a counter that must hold values 0..div.
  function automatic int unsigned seg_ser_div_cnt_w(input int unsigned div);
    return $clog2(div + 1);
  endfunction

endpackage

// File: rtl/seg_ser_tick.sv
// rtl/seg_ser_tick.sv - serial clock half-period divider
//
// Purpose: counts DIV system clocks while enabled and flags the last cycle of
// every half-period so the frame FSM can toggle the registered serial clock.
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   en_i        in   count enable; low holds the counter at zero
//   phase_end_o out  high in the last cycle of each DIV-cycle half-period
module seg_ser_tick
  import seg_ser_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic phase_end_o
);

  localparam int unsigned   CW   = seg_ser_div_cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Compare-and-clear: the counter never runs past LAST, so no wrap is relied on.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/seg_serializer.sv
// rtl/seg_serializer.sv - parallel-to-serial driver for the shift-register display chain
//
// Purpose: shifts WIDTH payload bits out on sdat with a registered serial clock
// (bit time 2*DIV clk cycles), with start/busy/done handshake and a one-deep
// pending request (latest request wins).
// Optional feature macro: SEG_SER_AUTO_UPDATE_EN - a change of data acts as a
// start request.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   data   in   parallel payload [WIDTH-1:0]
//   start  in   send request, single-cycle or held
//   busy   out  frame in progress (SETUP..DONE)
//   done   out  one-cycle pulse in DONE
//   sclk   out  serial clock (flop), downstream samples on its rising edge
//   sclr   out  downstream clear, active-low
//   sdat   out  serial data, changes only while sclk is low
//   sen    out  downstream enable, active-high
module seg_serializer
  import seg_ser_pkg::*;
#(
  parameter int unsigned WIDTH     = SEG_SER_DEF_WIDTH,
  parameter int unsigned DIV       = 1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             sclr,
  output logic             sdat,
  output logic             sen
);

  localparam int unsigned BW = $clog2(WIDTH + 1);

  seg_ser_state_e   state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pend_data_q, pend_data_d;
  logic [WIDTH-1:0] load_src;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             sclk_q, sclk_d;
  logic             sdat_q, sdat_d;
  logic             pend_q, pend_d;
  logic             start_q;
  logic             sclr_q, sen_q;
  logic             load, load_pend;
  logic             phase_end, last_bit_end;
  logic             chg, req_idle, req_new;

  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  seg_ser_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (state_q == ST_SHIFT),
    .phase_end_o(phase_end)
  );

`ifdef SEG_SER_AUTO_UPDATE_EN
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data;
    end
  end

  assign chg = (data != data_q);
`else
  assign chg = 1'b0;
`endif

  // In IDLE a start level launches a frame. While a frame is running only a
  // new request (rising edge of start, or a data change) is captured, so a
  // start held across the first cycles of its own frame counts once.
  assign req_idle = start || chg;
  assign req_new  = (start && !start_q) || chg;

  // End of the high phase of the final bit.
  assign last_bit_end = (state_q == ST_SHIFT) && phase_end && sclk_q &&
                        (bit_cnt_q == BW'(1));

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------- next-state comb
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_pend = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          load      = 1'b1;
          load_pend = 1'b1;
        end else if (req_idle) begin
          load = 1'b1;
        end
      end
      ST_SETUP: state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (last_bit_end) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (pend_q) begin
          load      = 1'b1;
          load_pend = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      state_d = ST_SETUP;
    end
  end

  // -------------------------------------------------------------- output comb
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    load_src  = load_pend ? pend_data_q : data;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    sdat_d    = sdat_q;
    if (load) begin
      shreg_d   = load_src;
      bit_cnt_d = BW'(WIDTH);
      sclk_d    = 1'b0;
      sdat_d    = first_bit(load_src);
    end else if ((state_q == ST_SHIFT) && phase_end) begin
      if (!sclk_q) begin
        sclk_d = 1'b1;
      end else begin
        // Falling sclk and the next bit share one edge, so sdat is never
        // updated while sclk is high.
        sclk_d    = 1'b0;
        bit_cnt_d = bit_cnt_q - BW'(1);
        if (last_bit_end) begin
          sdat_d = 1'b0;
        end else begin
          shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          sdat_d  = first_bit(shreg_d);
        end
      end
    end
  end

  // A request that is consumed and a new one arriving in the same cycle:
  // the new one survives as the next pending frame.
  always_comb begin
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    if (load_pend) begin
      pend_d = 1'b0;
    end
    if (req_new && ((state_q != ST_IDLE) || pend_q)) begin
      pend_d      = 1'b1;
      pend_data_d = data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      sclk_q      <= 1'b0;
      sdat_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      start_q     <= 1'b0;
      sclr_q      <= 1'b0;
      sen_q       <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      sclk_q      <= sclk_d;
      sdat_q      <= sdat_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      start_q     <= start;
      // Chain leaves clear and becomes enabled on the first edge after reset.
      sclr_q      <= 1'b1;
      sen_q       <= 1'b1;
    end
  end

  assign sclk = sclk_q;
  assign sdat = sdat_q;
  assign sclr = sclr_q;
  assign sen  = sen_q;

endmodule

// File: tb/tb_seg_serializer.sv
// tb/tb_seg_serializer.sv - scoreboard bench for seg_serializer (three configurations)
module tb_seg_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] data_a, data_b;
  logic [0:0]  data_c;
  logic        start_a, start_b, start_c;
  logic        busy_a, done_a, sclk_a, sclr_a, sdat_a, sen_a;
  logic        busy_b, done_b, sclk_b, sclr_b, sdat_b, sen_b;
  logic        busy_c, done_c, sclk_c, sclr_c, sdat_c, sen_c;

  always #5 clk = ~clk;

  seg_serializer #(.WIDTH(24), .DIV(1), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .data(data_a), .start(start_a), .busy(busy_a),
    .done(done_a), .sclk(sclk_a), .sclr(sclr_a), .sdat(sdat_a), .sen(sen_a));

  seg_serializer #(.WIDTH(24), .DIV(3), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .data(data_b), .start(start_b), .busy(busy_b),
    .done(done_b), .sclk(sclk_b), .sclr(sclr_b), .sdat(sdat_b), .sen(sen_b));

  seg_serializer #(.WIDTH(1), .DIV(2), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .data(data_c), .start(start_c), .busy(busy_c),
    .done(done_c), .sclk(sclk_c), .sclr(sclr_c), .sdat(sdat_c), .sen(sen_c));

  int cfg_w   [3] = '{24, 24, 1};
  int cfg_div [3] = '{1, 3, 2};
  bit cfg_msb [3] = '{1'b1, 1'b0, 1'b1};

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] q2[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [63:0] q_pop(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic logic busy_of(input int d);
    case (d)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // Bits in transmission order: r[j] is the j-th bit on the wire.
  function automatic logic [63:0] sent_order(input logic [63:0] v, input int w, input bit msb);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < w; j++) begin
      r[j] = msb ? v[w-1-j] : v[j];
    end
    return r;
  endfunction

  // ------------------------------------------------------------- monitor
  int          m_len [3];
  int          m_n   [3];
  int          m_run [3];
  bit          m_hadhigh [3];
  logic        m_psclk [3];
  logic        m_psdat [3];
  logic        m_pbusy [3];
  logic        m_pdone [3];
  logic [63:0] m_rx [3];

  task automatic mon_step(input int d, input logic b, input logic dn, input logic sc, input logic sd);
    logic [63:0] v;
    if (!rst_n) begin
      m_len[d] = 0; m_n[d] = 0; m_run[d] = 0; m_hadhigh[d] = 0; m_rx[d] = '0;
      m_psclk[d] = sc; m_psdat[d] = sd; m_pbusy[d] = 1'b0; m_pdone[d] = 1'b0;
      return;
    end
    if (dn) chk($sformatf("done_inside_busy[%0d]", d), 64'(b), 64'd1);
    if (!b && m_pbusy[d]) chk($sformatf("busy_falls_after_done[%0d]", d), 64'(m_pdone[d]), 64'd1);
    if (b) begin
      m_len[d]++;
      if (m_len[d] == 1) begin
        m_run[d] = 1; m_hadhigh[d] = 0; m_n[d] = 0; m_rx[d] = '0;
      end else begin
        if (sc) chk($sformatf("sdat_stable_sclk_high[%0d]", d), 64'(sd), 64'(m_psdat[d]));
        if (sc == m_psclk[d]) begin
          m_run[d]++;
        end else begin
          if (m_psclk[d])
            chk($sformatf("sclk_high_len[%0d]", d), 64'(m_run[d]), 64'(cfg_div[d]));
          else
            chk($sformatf("sclk_low_len[%0d]", d), 64'(m_run[d]),
                64'(m_hadhigh[d] ? cfg_div[d] : cfg_div[d] + 1));
          if (sc) begin
            m_hadhigh[d] = 1;
            if (m_n[d] < 64) m_rx[d][m_n[d]] = sd;
            m_n[d]++;
          end
          m_run[d] = 1;
        end
      end
      if (dn) begin
        chk($sformatf("done_lines_low[%0d]", d), 64'({sc, sd}), 64'd0);
        chk($sformatf("frame_len[%0d]", d), 64'(m_len[d]), 64'(2 + 2 * cfg_div[d] * cfg_w[d]));
        chk($sformatf("frame_bits[%0d]", d), 64'(m_n[d]), 64'(cfg_w[d]));
        chk($sformatf("frame_expected[%0d]", d), 64'(q_size(d) != 0), 64'd1);
        if (q_size(d) != 0) begin
          v = q_pop(d);
          chk($sformatf("frame_data[%0d]", d), m_rx[d], sent_order(v, cfg_w[d], cfg_msb[d]));
        end
        m_len[d] = 0;
      end
    end
    m_psclk[d] = sc; m_psdat[d] = sd; m_pbusy[d] = b; m_pdone[d] = dn;
  endtask

  always @(negedge clk) begin
    mon_step(0, busy_a, done_a, sclk_a, sdat_a);
    mon_step(1, busy_b, done_b, sclk_b, sdat_b);
    mon_step(2, busy_c, done_c, sclk_c, sdat_c);
  end

  // ------------------------------------------------------------ stimulus
  task automatic pulse_a(input logic [23:0] d, input bit lat);
    @(posedge clk); #1;
    data_a = d; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    if (lat) chk("start_latency_busy", 64'(busy_a), 64'd1);
  endtask

  task automatic pulse_b(input logic [23:0] d);
    @(posedge clk); #1;
    data_b = d; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget);
    int i;
    i = 0;
    while (i < budget && (q_size(d) != 0 || busy_of(d))) begin
      @(negedge clk);
      i++;
    end
    chk($sformatf("drain_in_time[%0d]", d), 64'(q_size(d) != 0 || busy_of(d)), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1);
  end

  initial begin
    logic [23:0] d, pend;
    int k, cnt;
    bit got;

    rst_n = 1'b0;
    data_a = '0; data_b = '0; data_c = '0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_a", 64'({busy_a, done_a, sclk_a, sdat_a, sclr_a, sen_a}), 64'd0);
    chk("reset_outputs_b", 64'({busy_b, done_b, sclk_b, sdat_b, sclr_b, sen_b}), 64'd0);
    chk("reset_outputs_c", 64'({busy_c, done_c, sclk_c, sdat_c, sclr_c, sen_c}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("sclr_sen_after_release", 64'({sclr_a, sen_a, sclr_b, sen_b}), 64'hF);

    // Frame 1: fixed pattern, MSB first, DIV=1.
    pulse_a(24'hA5F00F, 1'b1);
    q0.push_back(64'hA5F00F);
    wait_idle(0, 200);

    // Frame 2: LSB first, DIV=3.
    pulse_b(24'h000001);
    q1.push_back(64'h000001);
    wait_idle(1, 400);

    // Pending: latest request wins, second frame follows DONE directly.
    pulse_a(24'h111111, 1'b1);
    q0.push_back(64'h111111);
    repeat (5) @(posedge clk);
    pulse_a(24'h222222, 1'b0);
    repeat (3) @(posedge clk);
    pulse_a(24'h333333, 1'b0);
    q0.push_back(64'h333333);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done_a) got = 1'b1;
    end
    chk("pend_first_done_seen", 64'(got), 64'd1);
    @(negedge clk);
    chk("pend_back_to_back_busy", 64'(busy_a), 64'd1);
    wait_idle(0, 200);

    // Randomized frames with random overlapping requests.
    for (int f = 0; f < 6; f++) begin
      d = 24'($urandom);
      pulse_a(d, 1'b1);
      q0.push_back(64'(d));
      k = $urandom_range(0, 2);
      pend = '0;
      for (int j = 0; j < k; j++) begin
        repeat ($urandom_range(1, 10)) @(posedge clk);
        pend = 24'($urandom);
        pulse_a(pend, 1'b0);
      end
      if (k > 0) q0.push_back(64'(pend));
      wait_idle(0, 400);
    end

    // Reset mid-frame around bit 10: frame aborted, no done.
    pulse_a(24'($urandom), 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("rst_frame_in_flight", 64'(busy_a), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", 64'({busy_a, done_a, sclk_a, sdat_a, sclr_a, sen_a}), 64'd0);
    data_a = '0; data_b = '0; data_c = '0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_a) cnt++;
    end
    chk("rst_no_done", 64'(cnt), 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    chk("sclr_low_before_edge", 64'({sclr_a, sen_a}), 64'd0);
    @(posedge clk); #1;
    chk("sclr_high_after_edge", 64'({sclr_a, sen_a}), 64'h3);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy_a) cnt++;
    end
    chk("rst_no_resume", 64'(cnt), 64'd0);

    // Data change without start.
    @(posedge clk); #1;
    data_a = 24'h000123;
`ifdef SEG_SER_AUTO_UPDATE_EN
    q0.push_back(64'h000123);
    wait_idle(0, 200);
`endif
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy_a) cnt++;
    end
    chk("data_hold_no_frame", 64'(cnt), 64'd0);

    // WIDTH=1, DIV=2, start held three cycles and dropped before DONE.
    @(posedge clk); #1;
    data_c = 1'b1; start_c = 1'b1;
    q2.push_back(64'd1);
    repeat (3) @(posedge clk);
    #1 start_c = 1'b0;
    wait_idle(2, 50);
    repeat (20) @(negedge clk);

    chk("all_frames_seen", 64'(q_size(0) + q_size(1) + q_size(2)), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
